// File: rtl/sdram_arb_pkg.sv
// Shared types and helpers for the SDRAM command-port arbiter.
package sdram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_RSP,
        ACK
    } state_t;

    // Width of a port index; never narrower than one bit.
    function automatic int port_idx_w(input int num_ports);
        return (num_ports > 1) ? $clog2(num_ports) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker over ports 1..NUM_PORTS-1, starting after last.
module rr_pick
    import sdram_arb_pkg::*;
#(
    parameter int NUM_PORTS = 3,
    parameter int IDX_W     = port_idx_w(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [IDX_W-1:0]     last,
    output logic [IDX_W-1:0]     idx,
    output logic                 valid
);

    always_comb begin
        int               cand;
        logic [IDX_W-1:0] cand_idx;
        // NOTE: every output gets a default before the loop, otherwise the
        // paths that find no requester would infer latches.
        idx      = '0;
        valid    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int off = 1; off < NUM_PORTS; off++) begin
            // Map last+off into 1..NUM_PORTS-1, skipping the priority port.
            cand     = ((int'(last) + off - 1 + (NUM_PORTS - 1)) % (NUM_PORTS - 1)) + 1;
            cand_idx = IDX_W'(cand);
            if (!valid && req[cand_idx]) begin
                valid = 1'b1;
                idx   = cand_idx;
            end
        end
    end

endmodule

// File: rtl/sdram_arbiter.sv
// Single-outstanding arbiter for the SDRAM controller command port:
// port 0 has capped fixed priority, the remaining ports share round-robin.
module sdram_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int NUM_PORTS  = 3,
    parameter int ADDR_W     = 24,
    parameter int DATA_W     = 32,
    parameter int MAX_CONSEC = 4
) (
    input  logic                            clk,
    input  logic                            reset_i,
    input  logic [NUM_PORTS-1:0]            req_i,
    input  logic [NUM_PORTS-1:0]            we_i,
    input  logic [NUM_PORTS*ADDR_W-1:0]     addr_i,
    input  logic [NUM_PORTS*DATA_W-1:0]     wdata_i,
    input  logic [NUM_PORTS*DATA_W/8-1:0]   wmask_i,
    output logic [NUM_PORTS-1:0]            ack_o,
    output logic [DATA_W-1:0]               rdata_o,
    output logic                            cmd_valid_o,
    input  logic                            cmd_ready_i,
    output logic                            cmd_we_o,
    output logic [ADDR_W-1:0]               cmd_addr_o,
    output logic [DATA_W-1:0]               cmd_wdata_o,
    output logic [DATA_W/8-1:0]             cmd_wmask_o,
    input  logic                            rsp_valid_i,
    input  logic [DATA_W-1:0]               rsp_rdata_i,
    output logic [port_idx_w(NUM_PORTS)-1:0] grant_o,
    output logic                            busy_o
);

    localparam int IDX_W  = port_idx_w(NUM_PORTS);
    localparam int MASK_W = DATA_W / 8;
    localparam int CNT_W  = $clog2(MAX_CONSEC + 1);

    state_t           state;
    logic [IDX_W-1:0] rr_last;
    logic [CNT_W-1:0] consec_cnt;

    logic [ADDR_W-1:0] addr_a  [NUM_PORTS];
    logic [DATA_W-1:0] wdata_a [NUM_PORTS];
    logic [MASK_W-1:0] wmask_a [NUM_PORTS];

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_unpack
        assign addr_a[p]  = addr_i[p*ADDR_W +: ADDR_W];
        assign wdata_a[p] = wdata_i[p*DATA_W +: DATA_W];
        assign wmask_a[p] = wmask_i[p*MASK_W +: MASK_W];
    end

    logic             others_req;
    logic             cap_hit;
    logic             pick0;
    logic [IDX_W-1:0] rr_idx;
    logic             rr_valid;
    logic [IDX_W-1:0] win;

    rr_pick #(
        .NUM_PORTS (NUM_PORTS),
        .IDX_W     (IDX_W)
    ) u_rr_pick (
        .req   (req_i),
        .last  (rr_last),
        .idx   (rr_idx),
        .valid (rr_valid)
    );

    assign others_req = |req_i[NUM_PORTS-1:1];
    assign cap_hit    = (consec_cnt == CNT_W'(MAX_CONSEC)) && others_req;
    assign pick0      = req_i[0] && !cap_hit;
    // When port 0 loses, some other port is requesting, so rr_valid is set.
    assign win        = (pick0 || !rr_valid) ? '0 : rr_idx;

    // NOTE: all state here is sequential, so it is written with non-blocking
    // assignments only; blocking ones would race with the readers of these flops.
    always_ff @(posedge clk) begin
        if (reset_i) begin
            state       <= IDLE;
            rr_last     <= IDX_W'(NUM_PORTS - 1);
            consec_cnt  <= '0;
            ack_o       <= '0;
            rdata_o     <= '0;
            cmd_valid_o <= 1'b0;
            cmd_we_o    <= 1'b0;
            cmd_addr_o  <= '0;
            cmd_wdata_o <= '0;
            cmd_wmask_o <= '0;
            grant_o     <= '0;
            busy_o      <= 1'b0;
        end else begin
            ack_o <= '0;
            unique case (state)
                IDLE: begin
                    if (|req_i) begin
                        grant_o     <= win;
                        cmd_we_o    <= we_i[win];
                        cmd_addr_o  <= addr_a[win];
                        cmd_wdata_o <= wdata_a[win];
                        cmd_wmask_o <= wmask_a[win];
                        cmd_valid_o <= 1'b1;
                        busy_o      <= 1'b1;
                        state       <= ISSUE;
                        if (pick0) begin
                            // Only back-to-back wins against a waiting port count toward the cap.
                            if (!others_req)
                                consec_cnt <= '0;
                            else if (consec_cnt != CNT_W'(MAX_CONSEC))
                                consec_cnt <= consec_cnt + 1'b1;
                        end else begin
                            consec_cnt <= '0;
                            rr_last    <= rr_idx;
                        end
                    end
                end
                ISSUE: begin
                    if (cmd_ready_i) begin
                        cmd_valid_o <= 1'b0;
                        state       <= WAIT_RSP;
                    end
                end
                WAIT_RSP: begin
                    if (rsp_valid_i) begin
                        rdata_o         <= rsp_rdata_i;
                        ack_o[grant_o]  <= 1'b1;
                        state           <= ACK;
                    end
                end
                ACK: begin
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
